cmd_packet_rx: RTL and testbench
================================

# cmd_packet_rx

Command packet assembler that sits directly upstream of the parameter register bank (`control_param`). It takes the host byte stream from the interface FIFO, hunts for the 32-bit magic word 0xF0AA550F, and collects the following 4-byte command word. It then presents the {magic, command} pair on a valid/ready handshake to the parameter bank. Partial packets are discarded on inter-byte timeout, and drops are counted.

## Interface
Parameters:
- `MAGIC`, 32'hF0AA550F, sync word. It is compared MSB byte first.
- `TIMEOUT`, 16'd20000, idle clocks allowed between bytes inside a packet (1 ms at 20 MHz).

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `i_byte`  in  8  stream byte
- `i_byte_vld`  in  1  byte valid
- `o_byte_rdy`  out  1  byte accepted when `i_byte_vld && o_byte_rdy` at the clock edge
- `o_cmd_magic`  out  32  magic word to the parameter bank
- `o_cmd_command`  out  32  command word, big-endian (first byte is [31:24])
- `o_cmd_vld`  out  1  packet valid
- `i_cmd_rdy`  in  1  parameter bank ready
- `o_drop_cnt`  out  8  dropped-packet counter. Saturates at 255.
- `o_pkt_cnt`  out  16  delivered-packet counter. Wraps.

## Operation
States: HUNT, BODY, CHK (present only with the macro), OUT.

- **HUNT**
  - Each accepted byte shifts in: `win <= {win[23:0], i_byte}`.
  - If the shifted value equals `MAGIC`: go to BODY, set `bcnt=0`, clear `tmo`.
  - Overlapping magic matches are allowed. For example, F0 F0 AA 55 0F matches on the final byte.
- **BODY**
  - Each accepted byte: `cmd <= {cmd[23:0], i_byte}`, `bcnt++`.
  - On the 4th byte, go to OUT (or to CHK if the macro is defined).
- **OUT**
  - `o_cmd_vld=1`. `o_cmd_magic` and `o_cmd_command` are stable, and `o_byte_rdy=0`.
  - On `o_cmd_vld && i_cmd_rdy`: go to HUNT, set `win=0`, `o_pkt_cnt++`.
- **Byte handshake:** `o_byte_rdy = (state != OUT)`. This is combinational from state only and never depends on `i_byte_vld`.
- **Timeout (BODY/CHK only)**
  - `tmo` increments on every clock without an accepted byte and clears on every accepted byte.
  - When `tmo == TIMEOUT-1` with no byte that cycle: go to HUNT, set `win=0`, increment `o_drop_cnt` (saturating).
  - If a byte arrives on that same cycle, the byte wins and no timeout occurs.
  - HUNT and OUT never time out. The consumer may stall indefinitely.
- **Simultaneous events:** an accepted byte plus a timeout cannot occur together (the byte wins). A drop and a delivery cannot coincide in the same cycle.

## Timing
- **Reset values:** state=HUNT, `win=0`, `cmd=0`, `o_cmd_magic=0`, `o_cmd_command=0`, `o_cmd_vld=0`, `o_byte_rdy=1`, `o_drop_cnt=0`, `o_pkt_cnt=0`, `tmo=0`.
- **Latency:** `o_cmd_vld` rises on the clock edge that accepts the last command byte (or the CHK byte). It is visible the following cycle.
- **Magic output:** `o_cmd_magic` is loaded with `MAGIC` when entering OUT. It is otherwise held.
- **Throughput:** minimum 9 cycles per back-to-back packet with `i_cmd_rdy=1`:
  - 8 bytes
  - 1 OUT cycle, during which no byte is accepted
- **Reset mid-packet:** aborts immediately to reset values. No drop is counted.

## Configuration
- `CMD_PKT_CHK_EN` defined:
  - A 9th byte follows the command word.
  - It must equal the XOR of the 4 command bytes, `cmd[31:24]^cmd[23:16]^cmd[15:8]^cmd[7:0]`.
  - Match: go to OUT.
  - Mismatch: go to HUNT with `win=0`, increment `o_drop_cnt`, and leave `o_cmd_vld` low.
  - CHK is subject to the timeout.
- Not defined: CHK state, XOR logic and check byte are absent. The 8-byte packet goes straight to OUT.

## Structure
- Shared package `dscope_pkg` holds:
  - `CMD_MAGIC` = 32'hF0AA550F, shared with the parameter bank
  - the state enum for HUNT/BODY/CHK/OUT
  - the NCMD field position constants: `[31]` global, `[30:29]` channel, `[28:27]` slot, `[26:23]` ncmd
- Sub-module `cmd_rx_timeout`: the 16-bit idle counter, with inputs `clr` and `en` and output `expire`.

## Test plan
- **Clean packet:** bytes F0 AA 55 0F 01 88 00 14, `i_cmd_rdy=1` → one `o_cmd_vld` pulse with `o_cmd_command`=32'h01880014, `o_pkt_cnt`=1.
- **Resync:** leading garbage 12 F0 F0 AA 55 0F followed by 80 00 64 09 → command 32'h80006409 delivered and `o_drop_cnt`=0.
- **Backpressure:** `i_cmd_rdy=0` for 50 cycles after the packet → `o_cmd_vld` and `o_cmd_command` stay stable and `o_byte_rdy`=0 throughout. Releasing `i_cmd_rdy` gives exactly one transfer.
- **Timeout:** magic plus 2 command bytes, then idle for `TIMEOUT` cycles → `o_drop_cnt`=1 and state is HUNT. The next full packet is delivered correctly.
- **Timeout boundary:** a byte arrives exactly on the `TIMEOUT-1` idle cycle → no drop, and the packet completes.
- **Check byte (`CMD_PKT_CHK_EN`):** command 01 02 04 08 with check 0F → delivered. The same command with check 0E → no `o_cmd_vld`, and `o_drop_cnt` increments by 1.

Source files
------------

// File: rtl/dscope_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : dscope_pkg                                                   |
// | Shared definitions for the command path into the parameter bank:       |
// | the sync word, the packet-receiver state encoding and the NCMD field   |
// | positions inside a 32-bit command word.                                |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package dscope_pkg;

  // Sync word, also used by control_param to validate packets.
  localparam logic [31:0] CMD_MAGIC = 32'hF0AA550F;

  // Receiver states. CHK is only reachable when CMD_PKT_CHK_EN is defined.
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_BODY = 2'd1,
    ST_CHK  = 2'd2,
    ST_OUT  = 2'd3
  } rx_state_t;

  // NCMD field positions inside the command word.
  localparam int NCMD_GLOBAL_BIT = 31;
  localparam int NCMD_CHAN_MSB   = 30;
  localparam int NCMD_CHAN_LSB   = 29;
  localparam int NCMD_SLOT_MSB   = 28;
  localparam int NCMD_SLOT_LSB   = 27;
  localparam int NCMD_NCMD_MSB   = 26;
  localparam int NCMD_NCMD_LSB   = 23;

  // XOR of the four command bytes (check byte value).
  function automatic logic [7:0] cmd_xor(input logic [31:0] c);
    return c[31:24] ^ c[23:16] ^ c[15:8] ^ c[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_rx_timeout.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : cmd_rx_timeout                                               |
// | Inter-byte idle counter for the packet receiver.                       |
// | Ports   : clk, rst_n (async, active-low)                               |
// |           clr    - zero the counter (takes priority over en)           |
// |           en     - count one idle clock                                |
// |           expire - this idle clock is the TIMEOUT-th one               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module cmd_rx_timeout #(
  parameter logic [15:0] TIMEOUT = 16'd20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Counter holds the number of idle clocks already seen, so the
  // TIMEOUT-th idle clock is the one where cnt == TIMEOUT-1.
  assign expire = en && !clr && (cnt == (TIMEOUT - 16'd1));

endmodule
`default_nettype wire

// File: rtl/cmd_packet_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : cmd_packet_rx                                                |
// | Hunts the host byte stream for the sync word, collects the 4-byte      |
// | big-endian command that follows and offers {magic, command} to the     |
// | parameter bank on a valid/ready handshake. Partial packets are dropped |
// | on inter-byte timeout and counted.                                     |
// | Option  : define CMD_PKT_CHK_EN to require a trailing XOR check byte.  |
// | Ports   : clk, rst_n (async, active-low)                               |
// |           i_byte/i_byte_vld/o_byte_rdy  - input byte stream            |
// |           o_cmd_magic/o_cmd_command/o_cmd_vld/i_cmd_rdy - packet out   |
// |           o_drop_cnt (saturating), o_pkt_cnt (wrapping)                |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module cmd_packet_rx
  import dscope_pkg::*;
#(
  parameter logic [31:0] MAGIC   = CMD_MAGIC,
  parameter logic [15:0] TIMEOUT = 16'd20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_vld,
  output logic        o_byte_rdy,
  output logic [31:0] o_cmd_magic,
  output logic [31:0] o_cmd_command,
  output logic        o_cmd_vld,
  input  logic        i_cmd_rdy,
  output logic [7:0]  o_drop_cnt,
  output logic [15:0] o_pkt_cnt
);

  rx_state_t   state;
  logic [31:0] win;
  logic [31:0] cmd;
  logic [1:0]  bcnt;

  logic        byte_acc;
  logic        in_pkt;
  logic        tmo_expire;
  logic [31:0] win_next;
  logic [31:0] cmd_next;
  logic [7:0]  drop_inc;

  // Ready depends on state alone so the upstream FIFO never sees a loop.
  assign o_byte_rdy = (state != ST_OUT);
  assign byte_acc   = i_byte_vld && o_byte_rdy;
  assign in_pkt     = (state == ST_BODY) || (state == ST_CHK);
  assign win_next   = {win[23:0], i_byte};
  assign cmd_next   = {cmd[23:0], i_byte};
  assign drop_inc   = (o_drop_cnt == 8'hFF) ? 8'hFF : (o_drop_cnt + 8'd1);

  // Idle counting only runs inside a packet; everywhere else it is held
  // at zero so the first body byte always starts from a fresh count.
  cmd_rx_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (byte_acc || !in_pkt),
    .en     (in_pkt && !byte_acc),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_HUNT;
      win           <= '0;
      cmd           <= '0;
      bcnt          <= '0;
      o_cmd_magic   <= '0;
      o_cmd_command <= '0;
      o_cmd_vld     <= 1'b0;
      o_drop_cnt    <= '0;
      o_pkt_cnt     <= '0;
    end else begin
      case (state)
        ST_HUNT: begin
          if (byte_acc) begin
            win <= win_next;
            if (win_next == MAGIC) begin
              state <= ST_BODY;
              bcnt  <= '0;
            end
          end
        end

        ST_BODY: begin
          if (byte_acc) begin
            cmd  <= cmd_next;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
`ifdef CMD_PKT_CHK_EN
              state <= ST_CHK;
`else
              state         <= ST_OUT;
              o_cmd_vld     <= 1'b1;
              o_cmd_magic   <= MAGIC;
              o_cmd_command <= cmd_next;
`endif
            end
          end else if (tmo_expire) begin
            state      <= ST_HUNT;
            win        <= '0;
            o_drop_cnt <= drop_inc;
          end
        end

`ifdef CMD_PKT_CHK_EN
        ST_CHK: begin
          if (byte_acc) begin
            if (i_byte == cmd_xor(cmd)) begin
              state         <= ST_OUT;
              o_cmd_vld     <= 1'b1;
              o_cmd_magic   <= MAGIC;
              o_cmd_command <= cmd;
            end else begin
              state      <= ST_HUNT;
              win        <= '0;
              o_drop_cnt <= drop_inc;
            end
          end else if (tmo_expire) begin
            state      <= ST_HUNT;
            win        <= '0;
            o_drop_cnt <= drop_inc;
          end
        end
`endif

        ST_OUT: begin
          if (i_cmd_rdy) begin
            state     <= ST_HUNT;
            win       <= '0;
            o_cmd_vld <= 1'b0;
            o_pkt_cnt <= o_pkt_cnt + 16'd1;
          end
        end

        default: begin
          state <= ST_HUNT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_packet_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_cmd_packet_rx                                             |
// | Randomized scoreboard bench for cmd_packet_rx. The driver pushes the   |
// | command expected from each well-formed packet; a consumer/monitor      |
// | process pops and compares on every transfer. Build with               |
// | CMD_PKT_CHK_EN defined to exercise the check-byte variant.             |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_cmd_packet_rx;

  localparam int          TMO    = 24;
  localparam logic [31:0] MAGIC  = 32'hF0AA550F;

  logic        clk;
  logic        rst_n;
  logic [7:0]  i_byte;
  logic        i_byte_vld;
  logic        o_byte_rdy;
  logic [31:0] o_cmd_magic;
  logic [31:0] o_cmd_command;
  logic        o_cmd_vld;
  logic        i_cmd_rdy;
  logic [7:0]  o_drop_cnt;
  logic [15:0] o_pkt_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rdy_mode = 1;       // 0 random, 1 always ready, 2 stalled
  logic [31:0] exp_q[$];
  logic [15:0] exp_pkt = '0;
  int          exp_drop = 0;

  cmd_packet_rx #(
    .TIMEOUT (16'(TMO))
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_byte        (i_byte),
    .i_byte_vld    (i_byte_vld),
    .o_byte_rdy    (o_byte_rdy),
    .o_cmd_magic   (o_cmd_magic),
    .o_cmd_command (o_cmd_command),
    .o_cmd_vld     (o_cmd_vld),
    .i_cmd_rdy     (i_cmd_rdy),
    .o_drop_cnt    (o_drop_cnt),
    .o_pkt_cnt     (o_pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- consumer / monitor ----------------
  initial begin
    logic        held;
    logic        pending;
    logic [31:0] held_cmd;
    logic [31:0] e;
    held = 0; pending = 0; held_cmd = '0;
    i_cmd_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0; pending = 0; i_cmd_rdy = 1'b0;
        continue;
      end
      if (pending) begin
        check("pkt_cnt", 64'(o_pkt_cnt), 64'(exp_pkt));
        pending = 0;
      end
      if (o_cmd_vld) begin
        check("byte_rdy_in_out", 64'(o_byte_rdy), 64'd0);
        if (held) check("cmd_stable", 64'(o_cmd_command), 64'(held_cmd));
      end
      case (rdy_mode)
        0:       i_cmd_rdy = ($urandom_range(0, 9) < 7);
        1:       i_cmd_rdy = 1'b1;
        default: i_cmd_rdy = 1'b0;
      endcase
      if (o_cmd_vld && i_cmd_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pkt", 64'(o_cmd_command), 64'hDEAD_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("cmd_word", 64'(o_cmd_command), 64'(e));
          check("magic_word", 64'(o_cmd_magic), 64'(MAGIC));
        end
        exp_pkt = exp_pkt + 16'd1;
        pending = 1;
        held = 0;
      end else if (o_cmd_vld) begin
        held = 1;
        held_cmd = o_cmd_command;
      end else begin
        held = 0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int guard;
    acc = 0; guard = 0;
    while (!acc) begin
      @(negedge clk);
      i_byte = b;
      i_byte_vld = 1'b1;
      acc = o_byte_rdy;            // state cannot change before the next posedge
      @(posedge clk);
      guard++;
      if (guard > 2000) begin
        n_fail++;
        $display("FAIL byte_accept_timeout: got no ready expected ready");
        $fatal(1, "byte never accepted");
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_byte_vld = 1'b0;
    end
  endtask

  task automatic note_drop();
    exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
    @(negedge clk);
    i_byte_vld = 1'b0;
    check("drop_cnt", 64'(o_drop_cnt), 64'(exp_drop));
  endtask

  task automatic send_magic();
    send_byte(8'hF0); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0F);
  endtask

  // Body bytes with an optional idle gap before byte gap_idx; bad corrupts
  // the check byte (only meaningful in the check-byte build).
  task automatic send_cmd(input logic [31:0] c, input int gap_idx, input int gap_len,
                          input bit bad);
    logic [7:0] bytes[5];
    int nb;
    bytes[0] = c[31:24]; bytes[1] = c[23:16]; bytes[2] = c[15:8]; bytes[3] = c[7:0];
    bytes[4] = c[31:24] ^ c[23:16] ^ c[15:8] ^ c[7:0];
    if (bad) bytes[4] = bytes[4] ^ (8'd1 << $urandom_range(0, 7));
`ifdef CMD_PKT_CHK_EN
    nb = 5;
`else
    nb = 4;
`endif
    for (int i = 0; i < nb; i++) begin
      if (i == gap_idx) idle(gap_len);
      if (i == nb - 1 && !(bad && nb == 5)) exp_q.push_back(c);
      send_byte(bytes[i]);
    end
    if (bad && nb == 5) note_drop();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || o_cmd_vld) && g < 1000) begin
      @(negedge clk);
      i_byte_vld = 1'b0;
      g++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic int pick_gap();
    return ($urandom_range(0, 7) == 0) ? TMO - 1 : $urandom_range(0, 2);
  endfunction

  task automatic rand_packet();
    logic [31:0] gw;
    logic [31:0] c;
    logic [7:0]  b;
    int ng, nbody, k;
`ifdef CMD_PKT_CHK_EN
    nbody = 5;
`else
    nbody = 4;
`endif
    // Leading garbage, biased toward sync bytes but never forming the sync word.
    gw = '0;
    ng = $urandom_range(0, 6);
    for (int i = 0; i < ng; i++) begin
      case ($urandom_range(0, 4))
        0: b = 8'hF0;
        1: b = 8'hAA;
        2: b = 8'h55;
        3: b = 8'h0F;
        default: b = 8'($urandom);
      endcase
      if ({gw[23:0], b} == MAGIC) b = 8'h00;
      gw = {gw[23:0], b};
      send_byte(b);
      idle(($urandom_range(0, 15) == 0) ? TMO + 3 : $urandom_range(0, 2));
    end
    send_magic();
    c = $urandom;
    if ($urandom_range(0, 3) == 0) begin
      k = $urandom_range(0, nbody - 1);
      for (int i = 0; i < k; i++) begin
        idle(pick_gap());
        send_byte(8'(c >> (24 - 8 * i)));
      end
      idle(TMO + $urandom_range(0, 4));
      note_drop();
    end else begin
      k = $urandom_range(0, nbody - 1);
      send_cmd(c, k, pick_gap(), ($urandom_range(0, 3) == 0));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    i_byte = '0;
    i_byte_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_vld", 64'(o_cmd_vld), 64'd0);
    check("rst_byte_rdy", 64'(o_byte_rdy), 64'd1);
    check("rst_magic", 64'(o_cmd_magic), 64'd0);
    check("rst_command", 64'(o_cmd_command), 64'd0);
    check("rst_drop", 64'(o_drop_cnt), 64'd0);
    check("rst_pkt", 64'(o_pkt_cnt), 64'd0);
    rst_n = 1'b1;

    // Clean packet.
    rdy_mode = 1;
    send_magic();
    send_cmd(32'h01880014, 9, 0, 0);
    drain();
    check("clean_pkt_cnt", 64'(o_pkt_cnt), 64'd1);

    // Resync after garbage with an overlapping sync prefix.
    send_byte(8'h12);
    send_byte(8'hF0);
    send_magic();
    send_cmd(32'h80006409, 9, 0, 0);
    drain();
    check("resync_drop", 64'(o_drop_cnt), 64'd0);

    // Backpressure: consumer stalls 50 cycles.
    rdy_mode = 2;
    send_magic();
    send_cmd(32'hCAFE1234, 9, 0, 0);
    idle(50);
    check("bp_vld_held", 64'(o_cmd_vld), 64'd1);
    check("bp_pkt_cnt", 64'(o_pkt_cnt), 64'd2);
    rdy_mode = 1;
    drain();
    idle(2);
    check("bp_one_xfer", 64'(o_pkt_cnt), 64'd3);

    // Timeout after two command bytes, then a good packet.
    send_magic();
    send_byte(8'hAB); send_byte(8'hCD);
    idle(TMO);
    note_drop();
    check("tmo_drop_one", 64'(o_drop_cnt), 64'd1);
    send_magic();
    send_cmd(32'h11223344, 9, 0, 0);
    drain();

    // Byte on the last allowed idle cycle wins.
    send_magic();
    send_cmd(32'h55667788, 1, TMO - 1, 0);
    drain();
    check("boundary_no_drop", 64'(o_drop_cnt), 64'd1);

`ifdef CMD_PKT_CHK_EN
    send_magic();
    send_cmd(32'h01020408, 9, 0, 0);
    drain();
    send_magic();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h0E);
    note_drop();
    check("chk_bad_drop", 64'(o_drop_cnt), 64'd2);
`endif

    // Randomized traffic with a randomly stalling consumer.
    rdy_mode = 0;
    for (int p = 0; p < 200; p++) rand_packet();
    drain();

    // Drive the drop counter into saturation.
    rdy_mode = 1;
    for (int p = 0; p < 260; p++) begin
      send_magic();
      idle(TMO);
      note_drop();
    end
    check("drop_saturated", 64'(o_drop_cnt), 64'd255);

    // Reset in the middle of a packet: no drop, counters cleared.
    send_magic();
    send_byte(8'h99); send_byte(8'h88);
    @(negedge clk);
    i_byte_vld = 1'b0;
    rst_n = 1'b0;
    exp_pkt = '0;
    exp_drop = 0;
    @(negedge clk);
    check("midrst_drop", 64'(o_drop_cnt), 64'd0);
    check("midrst_pkt", 64'(o_pkt_cnt), 64'd0);
    check("midrst_rdy", 64'(o_byte_rdy), 64'd1);
    rst_n = 1'b1;
    send_magic();
    send_cmd(32'hA5A5F00F, 9, 0, 0);
    drain();
    idle(2);
    check("final_pkt_cnt", 64'(o_pkt_cnt), 64'd1);
    check("final_drop", 64'(o_drop_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
